// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer
//   Master-side SPI transfer sequencer. It accepts one word from the APB
//   register slice and drives slave select, which also gates the baud-rate
//   generator. It steps the MOSI/MISO shift registers on the generator's
//   sample/shift strobes and counts bits. It reports completion, write
//   collision and abort status back to the register slice.
//
//   Ports
//     pclk, preset_n           clock, async active-low reset
//     spi_mode_i, spiswai_i    run/wait/stop mode and stop-in-wait control
//     mstr_i                   master enable (0 parks the block in IDLE)
//     lsbfe_i                  1 = LSB first (latched per transfer)
//     send_data_i, tx_data_i   start pulse and the word to send
//     sample_strb_i,
//     shift_strb_i             phase-selected strobes from the baud generator
//     miso_i / mosi_o          serial data in / out
//     flag_clr_i               clears spif_o and wcol_o
//     ss_o                     slave select, active-low
//     rx_data_o, rx_valid_o    last received word and its update pulse
//     spif_o, wcol_o           sticky complete / write-collision flags
//     abort_o                  one-cycle pulse when a transfer is abandoned
//     busy_o                   high whenever not IDLE
//   All outputs come straight from flops.
module spi_xfer_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic [1:0]        spi_mode_i,
  input  logic              spiswai_i,
  input  logic              mstr_i,
  input  logic              lsbfe_i,
  input  logic              send_data_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              sample_strb_i,
  input  logic              shift_strb_i,
  input  logic              miso_i,
  input  logic              flag_clr_i,
  output logic              ss_o,
  output logic              mosi_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              spif_o,
  output logic              wcol_o,
  output logic              abort_o,
  output logic              busy_o
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);

  typedef enum logic [1:0] {IDLE, LOAD, XFER, DONE} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              lsb_q, lsb_d;
  logic              mosi_q, mosi_d;
  logic              ss_q, ss_d;
  logic              busy_q, busy_d;
  logic              rxv_q, rxv_d;
  logic              spif_q, spif_d;
  logic              wcol_q, wcol_d;
  logic              abort_q, abort_d;
  logic              en;
  logic              spif_set;
  logic              wcol_set;

  always_comb begin
    en = mstr_i & ((spi_mode_i == 2'b00) | ((spi_mode_i == 2'b01) & ~spiswai_i));
  end

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    cnt_d     = cnt_q;
    lsb_d     = lsb_q;
    mosi_d    = mosi_q;
    rxv_d     = 1'b0;
    abort_d   = 1'b0;
    spif_set  = 1'b0;
    wcol_set  = 1'b0;

    case (state_q)
      IDLE: begin
        if (send_data_i && en) begin
          state_d = LOAD;
          tx_d    = tx_data_i;
          // Present the first bit during LOAD itself; LOAD re-evaluates it
          // against the lsbfe_i value that actually gets latched.
          mosi_d  = lsbfe_i ? tx_data_i[0] : tx_data_i[DATA_W-1];
        end
      end
      LOAD: begin
        if (!en) begin
          state_d = IDLE;
          abort_d = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = XFER;
          cnt_d   = '0;
          lsb_d   = lsbfe_i;
          mosi_d  = lsbfe_i ? tx_q[0] : tx_q[DATA_W-1];
        end
      end
      XFER: begin
        if (!en) begin
          state_d = IDLE;
          abort_d = 1'b1;
          cnt_d   = '0;
        end else begin
          // Shift-ignore test uses the count before this cycle's sample.
          if (shift_strb_i && (cnt_q != CNT_FULL)) begin
            tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
            mosi_d = lsb_q ? tx_q[1] : tx_q[DATA_W-2];
          end
          if (sample_strb_i) begin
            rx_d  = lsb_q ? {miso_i, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso_i};
            cnt_d = cnt_q + 1'b1;
            // Completion outputs are registered together with the move to
            // DONE so that they are visible during the DONE cycle.
            if (cnt_q == CNT_LAST) begin
              state_d   = DONE;
              rx_data_d = rx_d;
              rxv_d     = 1'b1;
              spif_set  = 1'b1;
            end
          end
        end
      end
      DONE: begin
        // Re-assert the set during DONE so that a clear issued in this cycle loses.
        spif_set = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wcol_set = send_data_i & (state_q != IDLE);
    ss_d     = ~((state_d == LOAD) | (state_d == XFER));
    busy_d   = (state_d != IDLE);
    spif_d   = spif_set | (spif_q & ~flag_clr_i);
    wcol_d   = wcol_set | (wcol_q & ~flag_clr_i);
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      cnt_q     <= '0;
      lsb_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= 1'b1;
      busy_q    <= 1'b0;
      rxv_q     <= 1'b0;
      spif_q    <= 1'b0;
      wcol_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      cnt_q     <= cnt_d;
      lsb_q     <= lsb_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
      busy_q    <= busy_d;
      rxv_q     <= rxv_d;
      spif_q    <= spif_d;
      wcol_q    <= wcol_d;
      abort_q   <= abort_d;
    end
  end

  assign ss_o       = ss_q;
  assign mosi_o     = mosi_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rxv_q;
  assign spif_o     = spif_q;
  assign wcol_o     = wcol_q;
  assign abort_o    = abort_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer (DATA_W = 8).
module tb_spi_xfer_sequencer;

  localparam int W = 8;

  logic         pclk = 1'b0;
  logic         preset_n = 1'b0;
  logic [1:0]   spi_mode = 2'b00;
  logic         spiswai = 1'b0;
  logic         mstr = 1'b1;
  logic         lsbfe = 1'b0;
  logic         send = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         sample = 1'b0;
  logic         shift = 1'b0;
  logic         miso = 1'b0;
  logic         flag_clr = 1'b0;
  logic         ss_o, mosi_o, rx_valid_o, spif_o, wcol_o, abort_o, busy_o;
  logic [W-1:0] rx_data_o;

  spi_xfer_sequencer #(.DATA_W(W)) dut (
    .pclk(pclk), .preset_n(preset_n), .spi_mode_i(spi_mode), .spiswai_i(spiswai),
    .mstr_i(mstr), .lsbfe_i(lsbfe), .send_data_i(send), .tx_data_i(tx_data),
    .sample_strb_i(sample), .shift_strb_i(shift), .miso_i(miso), .flag_clr_i(flag_clr),
    .ss_o(ss_o), .mosi_o(mosi_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .spif_o(spif_o), .wcol_o(wcol_o), .abort_o(abort_o), .busy_o(busy_o)
  );

  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;
  int rxv_cnt = 0;
  int abort_cnt = 0;

  // Pulse counters, sampled mid-cycle.
  always @(negedge pclk) begin
    if (rx_valid_o) rxv_cnt <= rxv_cnt + 1;
    if (abort_o)    abort_cnt <= abort_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h required 'h%0h", nm, act, exp);
    end
  endtask

  // Reference: order in which tx bits leave the device, first bit at MSB.
  function automatic logic [W-1:0] sent_order(input logic lsb, input logic [W-1:0] x);
    logic [W-1:0] r, y;
    if (!lsb) return x;
    r = '0;
    y = x;
    for (int i = 0; i < W; i++) begin
      r = {r[W-2:0], y[0]};
      y = y >> 1;
    end
    return r;
  endfunction

  // Start a transfer and feed up to nbits sample(/shift) strobes.
  // Collects mosi before each sample into seq (first bit ends up at MSB).
  task automatic run_xfer(input logic lsb, input logic [W-1:0] tx, input logic [W-1:0] mw,
                          input logic coinc, input int col, input int nbits,
                          output logic [W-1:0] seq);
    logic [W-1:0] tmp;
    tx_data = tx;
    lsbfe = lsb;
    send = 1'b1;
    step();
    send = 1'b0;
    chk("load_ss_busy", 32'({ss_o, busy_o}), 'b01);
    step();
    // lsbfe is latched in LOAD; scrambling it now must not matter.
    lsbfe = 1'($urandom_range(0, 1));
    seq = '0;
    for (int i = 0; i < nbits; i++) begin
      seq = {seq[W-2:0], mosi_o};
      tmp = mw >> (lsb ? i : (W - 1 - i));
      miso = tmp[0];
      sample = 1'b1;
      shift = coinc;
      send = (i == col);
      step();
      sample = 1'b0;
      shift = 1'b0;
      send = 1'b0;
      if (!coinc && i != W - 1) begin
        shift = 1'b1;
        step();
        shift = 1'b0;
      end
    end
  endtask

  task automatic check_done(input logic [W-1:0] exp_rx, input logic exp_wcol);
    chk("done_flags", 32'({rx_valid_o, ss_o, spif_o, wcol_o, busy_o}),
        32'({4'b1110 | {3'b000, exp_wcol}, 1'b1}));
    chk("rx_data", 32'(rx_data_o), 32'(exp_rx));
  endtask

  typedef struct {
    logic         lsb;
    logic [W-1:0] tx;
    logic [W-1:0] mw;
    logic         coinc;
    int           col;
    logic [W-1:0] exp_rx;
    logic [W-1:0] exp_seq;
    logic         exp_wcol;
  } vec_t;

  vec_t         vt[5];
  logic [W-1:0] seq;
  logic [W-1:0] prev_rx;
  int           base, abase;

  initial begin
    vt[0] = '{lsb: 1'b0, tx: 8'hA5, mw: 8'h3C, coinc: 1'b0, col: -1, exp_rx: 8'h3C, exp_seq: 8'hA5, exp_wcol: 1'b0};
    vt[1] = '{lsb: 1'b1, tx: 8'h01, mw: 8'h80, coinc: 1'b0, col: -1, exp_rx: 8'h80, exp_seq: 8'h80, exp_wcol: 1'b0};
    vt[2] = '{lsb: 1'b0, tx: 8'h5A, mw: 8'hC3, coinc: 1'b1, col: -1, exp_rx: 8'hC3, exp_seq: 8'h5A, exp_wcol: 1'b0};
    vt[3] = '{lsb: 1'b1, tx: 8'h6B, mw: 8'h96, coinc: 1'b1, col: -1, exp_rx: 8'h96, exp_seq: 8'hD6, exp_wcol: 1'b0};
    vt[4] = '{lsb: 1'b0, tx: 8'h81, mw: 8'h55, coinc: 1'b0, col: 2,  exp_rx: 8'h55, exp_seq: 8'h81, exp_wcol: 1'b1};

    // Reset values
    #12;
    chk("reset_vals", 32'({ss_o, mosi_o, rx_valid_o, spif_o, wcol_o, abort_o, busy_o, rx_data_o}),
        32'({1'b1, 6'b0, 8'h00}));
    @(negedge pclk);
    preset_n = 1'b1;
    step();

    // Table-driven transfers
    foreach (vt[k]) begin
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      base = rxv_cnt;
      run_xfer(vt[k].lsb, vt[k].tx, vt[k].mw, vt[k].coinc, vt[k].col, W, seq);
      chk("mosi_seq", 32'(seq), 32'(vt[k].exp_seq));
      check_done(vt[k].exp_rx, vt[k].exp_wcol);
      step();
      chk("back_idle", 32'({busy_o, ss_o, rx_valid_o}), 'b010);
      chk("rxv_pulses", rxv_cnt - base, 1);
    end

    // Flags: clear during DONE loses to the set, clear next cycle wins
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    run_xfer(1'b0, 8'hC3, 8'h0F, 1'b0, 2, W, seq);
    check_done(8'h0F, 1'b1);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    chk("clr_in_done", 32'({spif_o, wcol_o}), 'b10);

    // New send accepted at S+2, with a same-cycle clear; abort from LOAD
    flag_clr = 1'b1;
    tx_data = 8'h3C;
    lsbfe = 1'b0;
    send = 1'b1;
    step();
    send = 1'b0;
    flag_clr = 1'b0;
    chk("accept_s2", 32'({busy_o, ss_o, spif_o, wcol_o}), 'b1000);
    mstr = 1'b0;
    abase = abort_cnt;
    step();
    mstr = 1'b1;
    chk("abort_load", 32'({abort_o, ss_o, busy_o}), 'b110);
    chk("abort_load_rx", 32'(rx_data_o), 'h0F);

    // Abort after 4 samples via stop mode
    prev_rx = rx_data_o;
    run_xfer(1'b0, 8'h96, 8'hF0, 1'b0, -1, 4, seq);
    chk("mid_ss", 32'({ss_o, busy_o}), 'b01);
    spi_mode = 2'b10;
    step();
    spi_mode = 2'b00;
    chk("abort_xfer", 32'({abort_o, ss_o, busy_o, spif_o, rx_valid_o}), 'b11000);
    chk("abort_rx_hold", 32'(rx_data_o), 32'(prev_rx));
    step();
    chk("abort_one_pulse", abort_cnt - abase, 2);
    chk("abort_low", 32'(abort_o), 0);

    // Wait mode with spiswai=0 runs normally
    spi_mode = 2'b01;
    spiswai = 1'b0;
    run_xfer(1'b1, 8'h2D, 8'hE1, 1'b0, -1, W, seq);
    chk("wait_seq", 32'(seq), 32'(sent_order(1'b1, 8'h2D)));
    check_done(8'hE1, 1'b0);
    step();

    // Sends while disabled are dropped silently
    spiswai = 1'b1;
    send = 1'b1;
    step();
    spi_mode = 2'b11;
    spiswai = 1'b0;
    step();
    mstr = 1'b0;
    spi_mode = 2'b00;
    step();
    send = 1'b0;
    mstr = 1'b1;
    step();
    chk("drop_send", 32'({busy_o, ss_o, wcol_o}), 'b010);

    // Reset in the middle of a transfer
    base = rxv_cnt;
    abase = abort_cnt;
    run_xfer(1'b0, 8'hA5, 8'h33, 1'b0, -1, 5, seq);
    #2;
    preset_n = 1'b0;
    #1;
    chk("reset_mid", 32'({ss_o, mosi_o, rx_valid_o, spif_o, wcol_o, abort_o, busy_o, rx_data_o}),
        32'({1'b1, 6'b0, 8'h00}));
    @(negedge pclk);
    preset_n = 1'b1;
    step();
    chk("reset_no_pulse", (rxv_cnt - base) + (abort_cnt - abase), 0);
    run_xfer(1'b0, 8'hFF, 8'h6D, 1'b0, -1, W, seq);
    chk("post_reset_seq", 32'(seq), 'hFF);
    check_done(8'h6D, 1'b0);
    step();

    // Randomized transfers against a transaction-level model
    for (int n = 0; n < 30; n++) begin
      logic         r_lsb, r_coinc;
      logic [W-1:0] r_tx, r_mw;
      int           r_col;
      r_lsb   = 1'($urandom_range(0, 1));
      r_coinc = 1'($urandom_range(0, 1));
      r_tx    = W'($urandom);
      r_mw    = W'($urandom);
      r_col   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      if ($urandom_range(0, 1) == 1) spi_mode = 2'b01;
      else spi_mode = 2'b00;
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      base = rxv_cnt;
      run_xfer(r_lsb, r_tx, r_mw, r_coinc, r_col, W, seq);
      chk("rnd_seq", 32'(seq), 32'(sent_order(r_lsb, r_tx)));
      check_done(r_mw, r_col >= 0);
      step();
      chk("rnd_idle", 32'({busy_o, ss_o, rx_valid_o}), 'b010);
      chk("rnd_rxv", rxv_cnt - base, 1);
    end
    spi_mode = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
